// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MIPS opcode/funct fields and the
// hazard controller state encoding.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    MDWAIT = 2'd2
  } hz_state_t;

  // $0 is hardwired, so a write to it never feeds a consumer.
  function automatic logic reg_hit(
    input logic [4:0] wr,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rt
  );
    return (wr != 5'd0) &&
           ((wr == rs) || (use_rt && (wr == rt)));
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// ID-stage operand decode for the hazard controller:
// source registers, branch class and HI/LO readers.
module hazard_decode
  import pipe_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        uses_rt,
  output logic        branch,
  output logic        hilo_use
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_imm;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign unused_imm = ^instr[15:6];

  always_comb begin
    uses_rt  = 1'b0;
    branch   = 1'b0;
    hilo_use = 1'b0;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        uses_rt  = 1'b1;
        branch   = (fn == FN_JR);
        hilo_use = (fn == FN_MFHI) || (fn == FN_MFLO) ||
                   (fn == FN_MULT) || (fn == FN_MULTU) ||
                   (fn == FN_DIV)  || (fn == FN_DIVU);
      end
      (op == OP_BEQ),
      (op == OP_BNE): begin
        uses_rt = 1'b1;
        branch  = 1'b1;
      end
      (op == OP_SW): uses_rt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/bubble/flush sequencing for hazards that
// forwarding cannot resolve (load-use, ID branch, HI/LO busy).
module hazard_stall_controller
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      ID_Instruction,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_WriteReg,
  input  logic             EXMEM_MemRead,
  input  logic [4:0]       EXMEM_WriteReg,
  input  logic             BranchTaken,
  input  logic             MulDivStart,
  input  logic             MulDivDone,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXBubble,
  output logic             IFIDFlush,
  output logic [CNT_W-1:0] StallCount,
  output logic [1:0]       HazardState
);

  hz_state_t  state;
  hz_state_t  state_nxt;
  logic [1:0] stall_left;
  logic [1:0] stall_left_nxt;
  logic       md_busy;

  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       branch;
  logic       hilo_use;

  logic       hit_ex;
  logic       hit_mem;
  logic       hz_md;
  logic       hz_br2;
  logic       hz_one;
  logic       hazard;
  logic       stall;

  hazard_decode u_dec (
    .instr    (ID_Instruction),
    .rs       (rs),
    .rt       (rt),
    .uses_rt  (uses_rt),
    .branch   (branch),
    .hilo_use (hilo_use)
  );

  assign hit_ex  = reg_hit(IDEX_WriteReg, rs, rt, uses_rt);
  assign hit_mem = reg_hit(EXMEM_WriteReg, rs, rt, uses_rt);

  assign hz_md  = md_busy && hilo_use && !MulDivDone;
  assign hz_br2 = branch && IDEX_RegWrite && hit_ex &&
                  IDEX_MemRead;
  assign hz_one = (IDEX_MemRead && hit_ex) ||
                  (branch && IDEX_RegWrite && hit_ex) ||
                  (branch && EXMEM_MemRead && hit_mem);
  assign hazard = hz_md || hz_br2 || hz_one;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= RUN;
      stall_left <= 2'd0;
    end else begin
      state      <= state_nxt;
      stall_left <= stall_left_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    stall_left_nxt = stall_left;
    unique case (state)
      RUN: begin
        if (hz_md) begin
          state_nxt = MDWAIT;
        end else if (hz_br2) begin
          state_nxt      = HOLD;
          stall_left_nxt = 2'd1;
        end
      end
      HOLD: begin
        if (stall_left != 2'd0)
          stall_left_nxt = stall_left - 2'd1;
        if (stall_left <= 2'd1)
          state_nxt = RUN;
      end
      MDWAIT: begin
        if (MulDivDone)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Reset forces pass-through even with hazardous inputs present.
  always_comb begin
    stall      = 1'b0;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    if (Reset) begin
      stall      = (state != RUN) || hazard;
      PCWrite    = !stall;
      IFIDWrite  = !stall;
      IDEXBubble = stall;
      IFIDFlush  = BranchTaken && !stall;
    end
  end

  assign HazardState = state;

  // Set wins over clear when a new op issues as the old one ends.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      md_busy <= 1'b0;
    else if (MulDivStart)
      md_busy <= 1'b1;
    else if (MulDivDone)
      md_busy <= 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      StallCount <= '0;
    else if (IDEXBubble && (StallCount != '1))
      StallCount <= StallCount +
                    {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed scoreboard bench for hazard_stall_controller,
// with a narrow-counter instance for saturation.
module tb_hazard_stall_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        ex_mr;
  logic        ex_rw;
  logic [4:0]  ex_wr;
  logic        mem_mr;
  logic [4:0]  mem_wr;
  logic        bt;
  logic        md_start;
  logic        md_done;

  logic        pc_w;
  logic        ifid_w;
  logic        bub;
  logic        flush;
  logic [15:0] cnt;
  logic [1:0]  st;

  logic        pc_w4;
  logic        ifid_w4;
  logic        bub4;
  logic        flush4;
  logic [3:0]  cnt4;
  logic [1:0]  st4;

  int checks;
  int errors;
  int exp_cnt;

  typedef struct {
    string       tag;
    logic        pc;
    logic        ifid;
    logic        bub;
    logic        fl;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] ADD_9_8_10 =
    {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] BEQ_8_0 =
    {6'h04, 5'd8, 5'd0, 16'h0004};
  localparam logic [31:0] SW_0_8 =
    {6'h2B, 5'd8, 5'd0, 16'h0000};
  localparam logic [31:0] ADD_9_0_0 =
    {6'h00, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] MFHI_2 =
    {6'h00, 10'd0, 5'd2, 5'd0, 6'h10};
  localparam logic [31:0] NOP = 32'h0;

  hazard_stall_controller dut (
    .Clock          (clk),
    .Reset          (rst_n),
    .ID_Instruction (instr),
    .IDEX_MemRead   (ex_mr),
    .IDEX_RegWrite  (ex_rw),
    .IDEX_WriteReg  (ex_wr),
    .EXMEM_MemRead  (mem_mr),
    .EXMEM_WriteReg (mem_wr),
    .BranchTaken    (bt),
    .MulDivStart    (md_start),
    .MulDivDone     (md_done),
    .PCWrite        (pc_w),
    .IFIDWrite      (ifid_w),
    .IDEXBubble     (bub),
    .IFIDFlush      (flush),
    .StallCount     (cnt),
    .HazardState    (st)
  );

  hazard_stall_controller #(.CNT_W(4)) dut4 (
    .Clock          (clk),
    .Reset          (rst_n),
    .ID_Instruction (instr),
    .IDEX_MemRead   (ex_mr),
    .IDEX_RegWrite  (ex_rw),
    .IDEX_WriteReg  (ex_wr),
    .EXMEM_MemRead  (mem_mr),
    .EXMEM_WriteReg (mem_wr),
    .BranchTaken    (bt),
    .MulDivStart    (md_start),
    .MulDivDone     (md_done),
    .PCWrite        (pc_w4),
    .IFIDWrite      (ifid_w4),
    .IDEXBubble     (bub4),
    .IFIDFlush      (flush4),
    .StallCount     (cnt4),
    .HazardState    (st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(
    input logic [31:0] i,
    input logic        emr,
    input logic        erw,
    input logic [4:0]  ewr,
    input logic        mmr,
    input logic [4:0]  mwr,
    input logic        b,
    input logic        ms,
    input logic        md
  );
    instr    = i;
    ex_mr    = emr;
    ex_rw    = erw;
    ex_wr    = ewr;
    mem_mr   = mmr;
    mem_wr   = mwr;
    bt       = b;
    md_start = ms;
    md_done  = md;
  endtask

  task automatic push(
    input string      tag,
    input logic       s,
    input logic       fl,
    input logic [1:0] es
  );
    exp_t e;
    e.tag  = tag;
    e.pc   = !s;
    e.ifid = !s;
    e.bub  = s;
    e.fl   = fl;
    e.st   = es;
    e.cnt  = 16'(exp_cnt);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (pc_w === e.pc) else begin
      errors++;
      $error("FAIL %s PCWrite got %b exp %b",
             e.tag, pc_w, e.pc);
    end
    checks++;
    assert (ifid_w === e.ifid) else begin
      errors++;
      $error("FAIL %s IFIDWrite got %b exp %b",
             e.tag, ifid_w, e.ifid);
    end
    checks++;
    assert (bub === e.bub) else begin
      errors++;
      $error("FAIL %s IDEXBubble got %b exp %b",
             e.tag, bub, e.bub);
    end
    checks++;
    assert (flush === e.fl) else begin
      errors++;
      $error("FAIL %s IFIDFlush got %b exp %b",
             e.tag, flush, e.fl);
    end
    checks++;
    assert (st === e.st) else begin
      errors++;
      $error("FAIL %s HazardState got %0d exp %0d",
             e.tag, st, e.st);
    end
    checks++;
    assert (cnt === e.cnt) else begin
      errors++;
      $error("FAIL %s StallCount got %0d exp %0d",
             e.tag, cnt, e.cnt);
    end
  endtask

  task automatic cyc(
    input string      tag,
    input logic       s,
    input logic       fl,
    input logic [1:0] es
  );
    push(tag, s, fl, es);
    @(negedge clk);
    pop_check();
    if (s && exp_cnt < 65535)
      exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic now(
    input string      tag,
    input logic       s,
    input logic       fl,
    input logic [1:0] es
  );
    push(tag, s, fl, es);
    pop_check();
  endtask

  initial begin
    int exp4;
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    rst_n   = 1'b0;
    drive(NOP, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(ADD_9_8_10, 1, 1, 5'd8, 0, 5'd0, 1, 0, 0);
    #1;
    now("reset_pass", 0, 0, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(ADD_9_8_10, 1, 1, 5'd8, 0, 5'd0, 0, 0, 0);
    cyc("lu_stall", 1, 0, 2'd0);
    drive(ADD_9_8_10, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    cyc("lu_after", 0, 0, 2'd0);

    drive(BEQ_8_0, 1, 1, 5'd8, 0, 5'd0, 0, 0, 0);
    cyc("br2_first", 1, 0, 2'd0);
    drive(NOP, 0, 0, 5'd0, 0, 5'd0, 1, 0, 0);
    cyc("br2_hold", 1, 0, 2'd1);
    drive(NOP, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    cyc("br2_done", 0, 0, 2'd0);

    drive(BEQ_8_0, 0, 0, 5'd0, 1, 5'd8, 0, 0, 0);
    cyc("br_mem_load", 1, 0, 2'd0);
    drive(SW_0_8, 0, 1, 5'd8, 0, 5'd0, 0, 0, 0);
    cyc("sw_no_stall", 0, 0, 2'd0);
    drive(ADD_9_0_0, 1, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    cyc("r0_no_stall", 0, 0, 2'd0);

    drive(NOP, 0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
    cyc("md_issue", 0, 0, 2'd0);
    drive(MFHI_2, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    cyc("md_enter", 1, 0, 2'd0);
    for (int i = 0; i < 4; i++)
      cyc("md_wait", 1, 0, 2'd2);
    md_done = 1'b1;
    cyc("md_done", 1, 0, 2'd2);
    md_done = 1'b0;
    cyc("md_resume", 0, 0, 2'd0);

    drive(NOP, 0, 0, 5'd0, 0, 5'd0, 0, 1, 1);
    cyc("md_set_wins", 0, 0, 2'd0);
    drive(MFHI_2, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    cyc("md_still_busy", 1, 0, 2'd0);
    md_done = 1'b1;
    cyc("md_done2", 1, 0, 2'd2);
    drive(NOP, 0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
    cyc("md_issue2", 0, 0, 2'd0);
    drive(MFHI_2, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    cyc("md_done_same", 0, 0, 2'd0);

    drive(ADD_9_8_10, 1, 1, 5'd8, 0, 5'd0, 1, 0, 0);
    cyc("flush_in_stall", 1, 0, 2'd0);
    drive(BEQ_8_0, 0, 0, 5'd0, 0, 5'd0, 1, 0, 0);
    cyc("flush_run", 0, 1, 2'd0);
    drive(BEQ_8_0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    cyc("flush_off", 0, 0, 2'd0);

    drive(BEQ_8_0, 1, 1, 5'd8, 0, 5'd0, 0, 0, 0);
    cyc("pre_hold", 1, 0, 2'd0);
    now("in_hold", 1, 0, 2'd1);
    #1;
    rst_n   = 1'b0;
    exp_cnt = 0;
    #1;
    now("reset_in_hold", 0, 0, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(ADD_9_8_10, 1, 1, 5'd8, 0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc("sat_run", 1, 0, 2'd0);
    drive(NOP, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    cyc("sat_end", 0, 0, 2'd0);
    exp4 = (exp_cnt > 15) ? 15 : exp_cnt;
    checks++;
    assert (cnt4 === 4'(exp4)) else begin
      errors++;
      $error("FAIL sat4 StallCount got %0d exp %0d",
             cnt4, exp4);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
